// File: rtl/sprite_plotter.sv
// Sprite pixel-write engine: erases the sprite at its previous position, then
// draws it at the requested one, one clipped pixel per clock.
//
//   state | meaning
//   IDLE  | waiting for move_req / hide_req
//   ERASE | painting the old square in the background colour
//   DRAW  | painting the new square in the latched colour
//   DONE  | one-cycle completion pulse, position/shown bookkeeping
module sprite_plotter #(
  parameter int         SPRITE_W  = 16,
  parameter int         SPRITE_H  = 16,
  parameter int         X_MAX     = 319,
  parameter int         Y_MAX     = 239,
  parameter logic [2:0] BG_COLOUR = 3'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_req,
  input  logic       hide_req,
  input  logic [8:0] new_x,
  input  logic [8:0] new_y,
  input  logic [2:0] colour_in,
  output logic       busy,
  output logic       done,
  output logic       plot,
  output logic [8:0] x_out,
  output logic [8:0] y_out,
  output logic [2:0] colour_out
);

  localparam int CW   = $clog2(SPRITE_W * SPRITE_H);
  localparam int XW   = $clog2(SPRITE_W);
  localparam int LAST = SPRITE_W * SPRITE_H - 1;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [8:0]    old_x, old_y;
  logic [8:0]    cur_x, cur_y, cur_x_nxt, cur_y_nxt;
  logic [2:0]    cur_colour, cur_colour_nxt;
  logic          shown;
  logic          is_move, is_move_nxt;
  logic          last_pix;

  logic [8:0]    base_x, base_y;
  logic [2:0]    pix_colour;
  logic [9:0]    sum_x, sum_y;
  logic          pix_on, plot_nxt;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cur_x_nxt      = cur_x;
    cur_y_nxt      = cur_y;
    cur_colour_nxt = cur_colour;
    is_move_nxt    = is_move;
    last_pix       = (cnt == CW'(LAST));
    case (state)
      IDLE: begin
        if (move_req) begin
          cur_x_nxt      = new_x;
          cur_y_nxt      = new_y;
          cur_colour_nxt = colour_in;
          is_move_nxt    = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = shown ? ERASE : DRAW;
        end else if (hide_req) begin
          is_move_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = shown ? ERASE : DONE;
        end
      end
      ERASE: begin
        if (last_pix) begin
          cnt_nxt   = '0;
          state_nxt = is_move ? DRAW : DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAW: begin
        if (last_pix) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel outputs are registered, so they are built from the state being entered.
  always_comb begin
    pix_on     = (state_nxt == ERASE) || (state_nxt == DRAW);
    base_x     = (state_nxt == ERASE) ? old_x : cur_x_nxt;
    base_y     = (state_nxt == ERASE) ? old_y : cur_y_nxt;
    pix_colour = (state_nxt == ERASE) ? BG_COLOUR : cur_colour_nxt;
    sum_x      = {1'b0, base_x} + 10'(cnt_nxt[XW-1:0]);
    sum_y      = {1'b0, base_y} + 10'(cnt_nxt[CW-1:XW]);
    plot_nxt   = pix_on && (sum_x <= 10'(X_MAX)) && (sum_y <= 10'(Y_MAX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_colour <= '0;
      is_move    <= 1'b0;
      old_x      <= '0;
      old_y      <= '0;
      shown      <= 1'b0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_x      <= cur_x_nxt;
      cur_y      <= cur_y_nxt;
      cur_colour <= cur_colour_nxt;
      is_move    <= is_move_nxt;
      if (state == DONE) begin
        if (is_move) begin
          old_x <= cur_x;
          old_y <= cur_y;
          shown <= 1'b1;
        end else begin
          shown <= 1'b0;
        end
      end
      plot       <= plot_nxt;
      x_out      <= plot_nxt ? sum_x[8:0] : 9'd0;
      y_out      <= plot_nxt ? sum_y[8:0] : 9'd0;
      colour_out <= plot_nxt ? pix_colour : 3'd0;
    end
  end

  assign busy = (state == ERASE) || (state == DRAW);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter: directed scenarios plus random requests, each
// compared cycle by cycle against a pixel-list model of the sprite moves.
module tb_sprite_plotter;

  logic       clock = 1'b0;
  logic       reset;
  logic       move_req, hide_req;
  logic [8:0] new_x, new_y;
  logic [2:0] colour_in;
  logic       busy, done, plot;
  logic [8:0] x_out, y_out;
  logic [2:0] colour_out;

  sprite_plotter dut (
    .clock(clock), .reset(reset),
    .move_req(move_req), .hide_req(hide_req),
    .new_x(new_x), .new_y(new_y), .colour_in(colour_in),
    .busy(busy), .done(done), .plot(plot),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // model: what is on screen
  bit          m_shown = 0;
  int          m_ox = 0, m_oy = 0;
  logic [23:0] exp_q[$];
  int          tail_plots;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] obs();
    return {busy, done, plot, x_out, y_out, colour_out};
  endfunction

  // one full square: row-major, column fastest, clipped to 320x240
  task automatic push_pass(input int bx, input int by, input int col);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int sx = bx + c;
        int sy = by + r;
        if (sx <= 319 && sy <= 239)
          exp_q.push_back({1'b1, 1'b0, 1'b1, 9'(sx), 9'(sy), 3'(col)});
        else
          exp_q.push_back({1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 3'd0});
      end
  endtask

  task automatic run_req(input bit mv, input bit hd, input int x, input int y, input int c,
                         input int poke_at, input int rst_at);
    @(negedge clock);
    move_req = mv; hide_req = hd;
    new_x = 9'(x); new_y = 9'(y); colour_in = 3'(c);
    exp_q.delete();
    if (mv) begin
      if (m_shown) push_pass(m_ox, m_oy, 0);
      push_pass(x, y, c);
    end else if (hd && m_shown) begin
      push_pass(m_ox, m_oy, 0);
    end
    @(posedge clock);
    #1;
    move_req = 1'b0; hide_req = 1'b0;
    new_x = 9'($urandom); new_y = 9'($urandom); colour_in = 3'($urandom);
    tail_plots = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      chk($sformatf("pix%0d", i), 32'(obs()), 32'(exp_q[i]));
      if (i >= exp_q.size() - 256 && plot) tail_plots++;
      if (i == rst_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_abort", 32'(obs()), 32'd0);
        m_shown = 0; m_ox = 0; m_oy = 0;
        repeat (4) begin
          @(negedge clock);
          chk("rst_quiet", 32'(obs()), 32'd0);
        end
        return;
      end
      if (poke_at >= 0) begin
        if (i == poke_at) move_req = 1'b1;
        if (i == poke_at + 3) move_req = 1'b0;
      end
    end
    @(negedge clock);
    chk("done", 32'(obs()), {8'd0, 1'b0, 1'b1, 22'd0});
    @(negedge clock);
    chk("idle", 32'(obs()), 32'd0);
    if (mv) begin
      m_shown = 1; m_ox = x; m_oy = y;
    end else if (hd) begin
      m_shown = 0;
    end
  endtask

  initial begin
    reset = 1'b1; move_req = 1'b0; hide_req = 1'b0;
    new_x = '0; new_y = '0; colour_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outs", 32'(obs()), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset", 32'(obs()), 32'd0);

    run_req(1, 0, 72, 96, 5, -1, -1);
    run_req(1, 0, 88, 96, 5, -1, -1);
    run_req(1, 0, 312, 232, 3, -1, -1);
    chk("clip_cnt", 32'(tail_plots), 32'd64);
    run_req(1, 0, 88, 96, 5, -1, -1);
    run_req(0, 1, 0, 0, 0, -1, -1);
    run_req(0, 1, 0, 0, 0, -1, -1);
    run_req(1, 1, 10, 20, 6, -1, -1);
    run_req(1, 0, 40, 50, 2, 300, -1);
    run_req(1, 0, 100, 100, 7, -1, 99);
    run_req(1, 0, 72, 96, 5, -1, -1);
    chk("redraw_len", 32'(exp_q.size()), 32'd256);

    for (int k = 0; k < 12; k++) begin
      bit mv = ($urandom_range(0, 3) != 0);
      bit hd = mv ? bit'($urandom_range(0, 1)) : 1'b1;
      run_req(mv, hd, $urandom_range(0, 511), $urandom_range(0, 511),
              $urandom_range(0, 7), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
# sprite_plotter

Pixel-write engine between the player/tile coordinate counters and the VGA frame-buffer write port. On request it erases a SPRITE_W x SPRITE_H square at the sprite's previous position with the background colour, then draws it at the new position. It emits one pixel per clock as plot/x_out/y_out/colour_out, clipped to the screen. A busy/done handshake tells the game controller when the move has finished.

## Interface
- SPRITE_W, 16, sprite width in pixels (power of two)
- SPRITE_H, 16, sprite height in pixels (power of two)
- X_MAX, 319, last visible column
- Y_MAX, 239, last visible row
- BG_COLOUR, 3'd0, colour used for erase
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- move_req  input  1  request: erase old sprite (if shown), draw at new_x/new_y
- hide_req  input  1  request: erase current sprite, mark it not shown
- new_x  input  9  target column of sprite top-left
- new_y  input  9  target row of sprite top-left
- colour_in  input  3  sprite colour for the draw pass
- busy  output  1  high while erasing or drawing
- done  output  1  one-cycle pulse when a request completes
- plot  output  1  frame-buffer write strobe
- x_out  output  9  pixel column
- y_out  output  9  pixel row
- colour_out  output  3  pixel colour

## Operation
- States: IDLE, ERASE, DRAW, DONE. Internal registers:
  - old_x/old_y: last drawn position
  - shown: sprite currently on screen
  - cur_x/cur_y/cur_colour: latched request
  - pixel counter: width log2(SPRITE_W*SPRITE_H)
- Requests are sampled only in IDLE. move_req has priority over hide_req. Requests arriving in ERASE/DRAW/DONE are ignored, not queued.
- IDLE + move_req:
  - latch new_x, new_y, colour_in and clear the counter.
  - If shown=1, go to ERASE; otherwise go to DRAW.
- IDLE + hide_req: go to ERASE if shown=1, otherwise go straight to DONE.
- ERASE:
  - One pixel per cycle at (old_x+col, old_y+row) in BG_COLOUR.
  - After the last pixel: go to DRAW if the request was a move, DONE if it was a hide.
  - Counter clears on the transition.
- DRAW:
  - One pixel per cycle at (cur_x+col, cur_y+row) in cur_colour.
  - After the last pixel go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - On a move, old_x/old_y take cur_x/cur_y and shown is set to 1. On a hide, shown is cleared.
- Scan order is row-major with column fastest: col = counter[log2(SPRITE_W)-1:0], row = counter upper bits.
- Arithmetic and clipping:
  - Coordinate sums are computed 10 bits wide.
  - A pixel whose sum exceeds X_MAX or Y_MAX still consumes its cycle, but plot=0 for it.
  - x_out/y_out carry the low 9 bits of the sum.
- plot, x_out, y_out and colour_out are registered. x_out, y_out and colour_out are 0 whenever plot=0.

## Timing
- Reset values: busy=0, done=0, plot=0, x_out=0, y_out=0, colour_out=0, shown=0, old_x=0, old_y=0, counter=0, state IDLE.
- Reset asserted mid-operation aborts at the next edge: no further plot, no done pulse, shown cleared.
- Request accepted at edge E0:
  - busy and plot go high after E0.
  - The first pixel (col 0, row 0) is valid in the cycle following E0.
- Pixel stream length:
  - Move with shown=1: 2*SPRITE_W*SPRITE_H consecutive pixel cycles (512 at defaults), erase then draw, with no gap.
  - Move with shown=0: SPRITE_W*SPRITE_H cycles (256).
  - Hide with shown=1: SPRITE_W*SPRITE_H cycles (256).
- done is high in the cycle immediately after the last pixel cycle. busy is low in that cycle.
- Hide with shown=0: done is high in the cycle after E0 and busy never rises.
- Earliest next acceptance is the edge ending the cycle after done, i.e. one IDLE cycle minimum.
- new_x, new_y and colour_in are don't-care after E0.

## Test plan
- Reset, then move_req (new_x=72, new_y=96, colour_in=3'd5):
  - 256 plot cycles; first pixel (72,96,5), 17th pixel (72,97,5), last (87,111,5).
  - done one cycle later; busy low throughout the done cycle.
- Second move_req to (88,96), colour 5:
  - 256 erase pixels (72..87, 96..111, colour 0), then 256 draw pixels at 88..103, with no gap.
  - done at cycle 513 after acceptance.
- Clipping: move to (312,232):
  - Still 256 cycles; plot=1 only for cols 312..319 and rows 232..239, i.e. 64 pixels.
  - x_out/y_out/colour_out are 0 when plot=0.
- hide_req with sprite shown at (88,96): 256 erase pixels, then done. A following hide_req gives done one cycle after acceptance, with no plot.
- move_req and hide_req asserted together in IDLE: move is executed. move_req asserted during DRAW: ignored, no extra pixels, one done only.
- reset pulsed at pixel 100 of an erase:
  - plot=0 and busy=0 from the next cycle, no done pulse.
  - The next move_req draws 256 pixels only, with no erase, since shown was cleared.
